fir_tap_loader: RTL and testbench
=================================

// Module: fir_tap_loader
// PURPOSE
//  Initiator side of the configurable FIR tap-programming interface.
//  Holds a shadow tap RAM, written through a simple config write port. On load_start it resets
//  the FIR (fir_enable low), then streams all N*M taps in ascending order on tap_dout/valid/ready.
//  Sits between the register/control plane and configurable_fir (tap_din*, enable).
// PARAMETERS
//  G_NUM_STAGES_LOG2   2   log2 FIR stages N; must match the FIR instance
//  G_STAGE_DEPTH_LOG2  2   log2 stage depth M; must match the FIR instance
//  G_TAP_WIDTH        16   tap word width
//  G_FLUSH_CYCLES      2   cycles fir_enable is held low before streaming (>=1)
//  derived: ADDR_W = G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2; NUM_TAPS = 2**ADDR_W
// PORTS
//  clk             in   1        single clock
//  reset           in   1        reset, synchronous, active-low (0 = reset)
//  cfg_wr_addr     in   ADDR_W   shadow tap address (= bank*M + depth index)
//  cfg_wr_data     in   TAP_W    tap value
//  cfg_wr_valid    in   1        write request
//  cfg_wr_ready    out  1        write accepted when valid&ready
//  load_start      in   1        request a full tap load (level sampled per cycle)
//  busy            out  1        load in progress
//  load_done       out  1        1-cycle pulse on the final tap handshake
//  taps_valid      out  1        FIR contents match the shadow RAM
//  fir_enable      out  1        drives FIR enable
//  tap_dout        out  TAP_W    tap word to FIR tap_din
//  tap_dout_valid  out  1        tap word valid
//  tap_dout_ready  in   1        FIR tap_din_ready
// BEHAVIOUR
//  Reset (reset==0 at a clk edge): state IDLE; busy, load_done, taps_valid, fir_enable,
//   tap_dout_valid = 0; tap_dout = 0; skid emptied; read/stream counters = 0. Shadow RAM not cleared.
//  All outputs are registered except cfg_wr_ready = (state==IDLE || state==DONE).
//  States: IDLE -> FLUSH -> STREAM -> DONE; DONE behaves as IDLE, except fir_enable stays 1.
//   IDLE/DONE: cfg write on valid&ready: RAM[addr] <= data; taps_valid <= 0 in the same cycle.
//    If load_start==1 (and no cfg write in that cycle): go to FLUSH, busy<=1, taps_valid<=0,
//    fir_enable<=0, flush counter<=0.
//    A simultaneous cfg write and load_start: the write wins, load_start is ignored that cycle.
//   FLUSH: fir_enable held 0 for exactly G_FLUSH_CYCLES cycles. Then fir_enable<=1, rd_addr<=0,
//    go to STREAM.
//   STREAM: RAM read latency is 1 cycle. Reads feed the skid; a read is issued only when the skid
//    has room counting in-flight reads. rd_addr increments 0..NUM_TAPS-1 and never wraps.
//    Output beat on tap_dout_valid & tap_dout_ready. Taps leave in strict address order.
//    No drop, no duplication. tap_dout is stable while valid & !ready.
//    With ready held 1, one beat per cycle. First valid appears 1 cycle after fir_enable rises.
//    Final beat (count NUM_TAPS-1): load_done<=1 for 1 cycle, taps_valid<=1, busy<=0,
//    tap_dout_valid<=0, go to DONE.
//  load_start while busy: ignored; it is neither queued nor counted.
//  cfg writes while busy: stalled by cfg_wr_ready=0. No write is lost.
//  Reset mid-load: abort; all outputs return to reset values on the next edge.
//   A later load restarts from address 0.
//  Latency: load_start sampled at edge T -> fir_enable 0 for T+1..T+G_FLUSH_CYCLES
//   -> fir_enable 1 at T+G_FLUSH_CYCLES+1 -> first tap_dout_valid at T+G_FLUSH_CYCLES+2.
//  Width rules: no arithmetic on tap data. Counters are ADDR_W+1 bits so the terminal count
//   NUM_TAPS is representable.
// STRUCTURE
//  Package fir_tap_loader_pkg: state_t enum (SM_IDLE, SM_FLUSH, SM_STREAM, SM_DONE);
//   a function for num_taps(stages_log2, depth_log2).
//  Sub-module fir_tap_skid: 2-entry valid/ready skid buffer, param G_DATA_WIDTH.
//   Its count output is used for read-issue throttling.
//  Shadow RAM: inferred simple dual-port, synchronous read, in this file.
// TESTING (defaults N=4, M=4, NUM_TAPS=16)
//  1 Write RAM[i]=16'h0100+i for i=0..15, pulse load_start, ready=1 -> fir_enable low 2 cycles;
//    16 consecutive beats 0x0100..0x010F; load_done pulse on beat 15; taps_valid=1.
//  2 Same taps, tap_dout_ready pattern 1,0,0,1 repeating -> identical 16-beat sequence;
//    tap_dout unchanged while valid&!ready; exactly one load_done.
//  3 load_start held high during STREAM -> no second load; cfg write during STREAM ->
//    cfg_wr_ready=0 until DONE, then write commits and taps_valid drops to 0.
//  4 Assert reset (0) at beat 7 -> next cycle valid=0, fir_enable=0, busy=0; re-load ->
//    beats restart at 0x0100.
//  5 Back-to-back loads from DONE -> fir_enable drops again for G_FLUSH_CYCLES;
//    taps_valid 0 during the load, 1 at its end.
//  6 Connected to configurable_fir (same params): load RAM[0]=16'h7FFF, others 0 ->
//    FIR din_ready rises after beat 15; FIR accepts samples afterwards.

Source files
------------

// File: rtl/fir_tap_loader_pkg.sv
// Shared types and helpers for the FIR tap loader.
//   state_t   : loader FSM encoding (IDLE -> FLUSH -> STREAM -> DONE)
//   num_taps  : total tap count of an N-stage, M-deep FIR given log2 N and log2 M
package fir_tap_loader_pkg;

    typedef enum logic [1:0] {
        SM_IDLE   = 2'd0,
        SM_FLUSH  = 2'd1,
        SM_STREAM = 2'd2,
        SM_DONE   = 2'd3
    } state_t;

    function automatic int num_taps(input int stages_log2, input int depth_log2);
        return 1 << (stages_log2 + depth_log2);
    endfunction

endpackage

// File: rtl/fir_tap_skid.sv
// Two-entry valid/ready skid buffer between the shadow RAM read port and the FIR tap input.
// The upstream side has no ready: the producer must only push when count (plus its own
// in-flight reads) leaves room.
// Ports:
//   clk, reset (sync, active-low)
//   in_data / in_valid     : word entering the buffer
//   out_data / out_valid   : registered head of the buffer
//   out_ready              : downstream accepts the head this cycle
//   count                  : number of words held (0..2)
module fir_tap_skid #(
    parameter int G_DATA_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [G_DATA_WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic [G_DATA_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              count
);

    logic [G_DATA_WIDTH-1:0] spare_data;
    logic                    spare_valid;
    logic                    pop;

    assign pop   = out_valid & out_ready;
    assign count = {1'b0, out_valid} + {1'b0, spare_valid};

    // Head register: refilled from the spare first so order is preserved
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            spare_valid <= 1'b0;
            out_data    <= '0;
        end else begin
            if (!out_valid || pop) begin
                if (spare_valid) begin
                    out_valid   <= 1'b1;
                    out_data    <= spare_data;
                    spare_valid <= in_valid;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        out_data <= in_data;
                    end
                end
            end else if (in_valid) begin
                spare_valid <= 1'b1;
            end
        end
    end

    // Spare register: catches the incoming word whenever the head cannot take it directly
    always_ff @(posedge clk) begin
        if (in_valid && ((out_valid && !pop) || spare_valid)) begin
            spare_data <= in_data;
        end
    end

endmodule

// File: rtl/fir_tap_loader.sv
// Initiator side of the FIR tap-programming interface. A shadow tap RAM is filled through
// the cfg write port; on load_start the FIR is held in reset (fir_enable low) for
// G_FLUSH_CYCLES cycles and then every tap is streamed in ascending address order.
// Ports:
//   clk, reset (sync, active-low)
//   cfg_wr_addr/data/valid, cfg_wr_ready : shadow RAM write port (ready only when idle/done)
//   load_start                           : level request for a full tap load
//   busy, load_done, taps_valid          : load status (load_done pulses on the last beat)
//   fir_enable                           : FIR enable, low during the flush window
//   tap_dout/tap_dout_valid/tap_dout_ready : tap stream towards the FIR tap_din port
module fir_tap_loader
    import fir_tap_loader_pkg::*;
#(
    parameter int G_NUM_STAGES_LOG2  = 2,
    parameter int G_STAGE_DEPTH_LOG2 = 2,
    parameter int G_TAP_WIDTH        = 16,
    parameter int G_FLUSH_CYCLES     = 2
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [G_NUM_STAGES_LOG2+G_STAGE_DEPTH_LOG2-1:0] cfg_wr_addr,
    input  logic [G_TAP_WIDTH-1:0]                        cfg_wr_data,
    input  logic                                          cfg_wr_valid,
    output logic                                          cfg_wr_ready,
    input  logic                                          load_start,
    output logic                                          busy,
    output logic                                          load_done,
    output logic                                          taps_valid,
    output logic                                          fir_enable,
    output logic [G_TAP_WIDTH-1:0]                        tap_dout,
    output logic                                          tap_dout_valid,
    input  logic                                          tap_dout_ready
);

    localparam int ADDR_W   = G_NUM_STAGES_LOG2 + G_STAGE_DEPTH_LOG2;
    localparam int NUM_TAPS = num_taps(G_NUM_STAGES_LOG2, G_STAGE_DEPTH_LOG2);
    localparam int FLUSH_W  = $clog2(G_FLUSH_CYCLES + 1);

    localparam logic [ADDR_W:0]    TAP_END    = (ADDR_W+1)'(NUM_TAPS);
    localparam logic [ADDR_W:0]    LAST_BEAT  = (ADDR_W+1)'(NUM_TAPS - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(G_FLUSH_CYCLES - 1);

    state_t               state;
    logic [FLUSH_W-1:0]   flush_cnt;
    logic [ADDR_W:0]      rd_addr;
    logic [ADDR_W:0]      beat_cnt;

    logic [G_TAP_WIDTH-1:0] mem [NUM_TAPS];
    logic [G_TAP_WIDTH-1:0] ram_q_p1;
    logic                   rd_vld_p1;

    logic       cfg_wr;
    logic       pop;
    logic       rd_window;
    logic       rd_en;
    logic [1:0] skid_count;
    logic [2:0] occ_after;

    assign cfg_wr_ready = (state == SM_IDLE) || (state == SM_DONE);
    assign cfg_wr       = cfg_wr_valid & cfg_wr_ready;
    assign pop          = tap_dout_valid & tap_dout_ready;

    // The first read goes out in the last flush cycle so the first tap is presented
    // exactly one cycle after fir_enable rises. Room is judged after this cycle's pop,
    // counting the read already in flight, so the skid never overflows yet still
    // sustains one beat per cycle.
    assign rd_window = (state == SM_STREAM) ||
                       ((state == SM_FLUSH) && (flush_cnt == FLUSH_LAST));
    assign occ_after = {1'b0, skid_count} + {2'b0, rd_vld_p1} - {2'b0, pop};
    assign rd_en     = rd_window && (rd_addr != TAP_END) && (occ_after < 3'd2);

    // Stage p0: shadow RAM write and control FSM
    always_ff @(posedge clk) begin
        if (cfg_wr) begin
            mem[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SM_IDLE;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            taps_valid <= 1'b0;
            fir_enable <= 1'b0;
            flush_cnt  <= '0;
            rd_addr    <= '0;
            beat_cnt   <= '0;
            rd_vld_p1  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            rd_vld_p1 <= rd_en;
            if (rd_en) begin
                rd_addr <= rd_addr + 1'b1;
            end

            case (state)
                SM_IDLE, SM_DONE: begin
                    // A write in the same cycle as load_start takes priority
                    if (cfg_wr) begin
                        taps_valid <= 1'b0;
                    end else if (load_start) begin
                        state      <= SM_FLUSH;
                        busy       <= 1'b1;
                        taps_valid <= 1'b0;
                        fir_enable <= 1'b0;
                        flush_cnt  <= '0;
                        rd_addr    <= '0;
                        beat_cnt   <= '0;
                    end
                end
                SM_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        fir_enable <= 1'b1;
                        state      <= SM_STREAM;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                SM_STREAM: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            load_done  <= 1'b1;
                            taps_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= SM_DONE;
                        end
                    end
                end
                default: state <= SM_IDLE;
            endcase
        end
    end

    // Stage p1: synchronous RAM read
    always_ff @(posedge clk) begin
        if (rd_en) begin
            ram_q_p1 <= mem[rd_addr[ADDR_W-1:0]];
        end
    end

    // Stage p2: skid buffer drives the registered tap stream
    fir_tap_skid #(
        .G_DATA_WIDTH(G_TAP_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_data  (ram_q_p1),
        .in_valid (rd_vld_p1),
        .out_data (tap_dout),
        .out_valid(tap_dout_valid),
        .out_ready(tap_dout_ready),
        .count    (skid_count)
    );

endmodule

// File: tb/tb_fir_tap_loader.sv
module tb_fir_tap_loader;

    localparam int TW = 16;
    localparam int AW = 4;
    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] cfg_wr_addr;
    logic [TW-1:0] cfg_wr_data;
    logic          cfg_wr_valid;
    logic          cfg_wr_ready;
    logic          load_start;
    logic          busy;
    logic          load_done;
    logic          taps_valid;
    logic          fir_enable;
    logic [TW-1:0] tap_dout;
    logic          tap_dout_valid;
    logic          tap_dout_ready;

    always #5 clk = ~clk;

    fir_tap_loader #(
        .G_NUM_STAGES_LOG2 (2),
        .G_STAGE_DEPTH_LOG2(2),
        .G_TAP_WIDTH       (16),
        .G_FLUSH_CYCLES    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_wr_addr   (cfg_wr_addr),
        .cfg_wr_data   (cfg_wr_data),
        .cfg_wr_valid  (cfg_wr_valid),
        .cfg_wr_ready  (cfg_wr_ready),
        .load_start    (load_start),
        .busy          (busy),
        .load_done     (load_done),
        .taps_valid    (taps_valid),
        .fir_enable    (fir_enable),
        .tap_dout      (tap_dout),
        .tap_dout_valid(tap_dout_valid),
        .tap_dout_ready(tap_dout_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [TW-1:0] beats [0:63];
    int nbeats, ndone, nunstable, done_beat, first_cyc, last_cyc;
    bit tmo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [TW-1:0] d);
        cfg_wr_addr  = a;
        cfg_wr_data  = d;
        cfg_wr_valid = 1'b1;
        tick();
        cfg_wr_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Records the tap stream until load_done plus a few trailing cycles.
    task automatic collect(input bit stall_pat, input int budget);
        bit            held_v;
        bit            done_seen;
        logic [TW-1:0] held_d;
        int            extra;
        nbeats = 0; ndone = 0; nunstable = 0; done_beat = -1;
        first_cyc = -1; last_cyc = -1; tmo = 0;
        held_v = 0; held_d = '0; done_seen = 0; extra = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            tap_dout_ready = stall_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (load_done === 1'b1) begin
                ndone++;
                if (!done_seen) done_beat = nbeats;
                done_seen = 1;
            end
            if (held_v && ((tap_dout_valid !== 1'b1) || (tap_dout !== held_d))) nunstable++;
            held_v = (tap_dout_valid === 1'b1) && !tap_dout_ready;
            held_d = tap_dout;
            if ((tap_dout_valid === 1'b1) && tap_dout_ready) begin
                if (nbeats < 64) beats[nbeats] = tap_dout;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nbeats++;
            end
            if (done_seen) begin
                extra++;
                if (extra > 4) break;
            end
            tick();
        end
        if (!done_seen) tmo = 1;
        tap_dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_load_done got %b exp 0", load_done); end
        n_checks++; if (taps_valid !== 1'b0) begin n_fail++; $display("FAIL reset_taps_valid got %b exp 0", taps_valid); end
        n_checks++; if (fir_enable !== 1'b0) begin n_fail++; $display("FAIL reset_fir_enable got %b exp 0", fir_enable); end
        n_checks++; if (tap_dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", tap_dout_valid); end
        n_checks++; if (tap_dout !== 16'h0000) begin n_fail++; $display("FAIL reset_dout got %h exp 0000", tap_dout); end
        n_checks++; if (cfg_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b exp 1", cfg_wr_ready); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        for (int i = 0; i < NT; i++) write_word(AW'(i), 16'h0100 + 16'(i));
        n_checks++; if (taps_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_taps_valid got %b exp 0", taps_valid); end
        tap_dout_ready = 1'b1;
        start_load();
        n_checks++; if (fir_enable !== 1'b0) begin n_fail++; $display("FAIL basic_fe_t1 got %b exp 0", fir_enable); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
        tick();
        n_checks++; if (fir_enable !== 1'b0) begin n_fail++; $display("FAIL basic_fe_t2 got %b exp 0", fir_enable); end
        tick();
        n_checks++; if (fir_enable !== 1'b1) begin n_fail++; $display("FAIL basic_fe_t3 got %b exp 1", fir_enable); end
        n_checks++; if (tap_dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_t3 got %b exp 0", tap_dout_valid); end
        tick();
        n_checks++; if (tap_dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_t4 got %b exp 1", tap_dout_valid); end
        n_checks++; if (tap_dout !== 16'h0100) begin n_fail++; $display("FAIL basic_first_tap got %h exp 0100", tap_dout); end
        collect(1'b0, 100);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got %b exp 0", tmo); end
        n_checks++; if (nbeats !== NT) begin n_fail++; $display("FAIL basic_nbeats got %0d exp %0d", nbeats, NT); end
        for (int i = 0; i < NT; i++) begin
            n_checks++;
            if (beats[i] !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL basic_beat%0d got %h exp %h", i, beats[i], 16'h0100 + 16'(i)); end
        end
        n_checks++; if (last_cyc - first_cyc !== NT - 1) begin n_fail++; $display("FAIL basic_span got %0d exp %0d", last_cyc - first_cyc, NT - 1); end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL basic_ndone got %0d exp 1", ndone); end
        n_checks++; if (done_beat !== NT) begin n_fail++; $display("FAIL basic_done_pos got %0d exp %0d", done_beat, NT); end
        n_checks++; if (taps_valid !== 1'b1) begin n_fail++; $display("FAIL basic_taps_valid got %b exp 1", taps_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", busy); end
        n_checks++; if (fir_enable !== 1'b1) begin n_fail++; $display("FAIL basic_fe_done got %b exp 1", fir_enable); end
    endtask

    task automatic test_backpressure();
        start_load();
        collect(1'b1, 200);
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got %b exp 0", tmo); end
        n_checks++; if (nbeats !== NT) begin n_fail++; $display("FAIL bp_nbeats got %0d exp %0d", nbeats, NT); end
        for (int i = 0; i < NT; i++) begin
            n_checks++;
            if (beats[i] !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL bp_beat%0d got %h exp %h", i, beats[i], 16'h0100 + 16'(i)); end
        end
        n_checks++; if (nunstable !== 0) begin n_fail++; $display("FAIL bp_stable got %0d exp 0", nunstable); end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL bp_ndone got %0d exp 1", ndone); end
        n_checks++; if (taps_valid !== 1'b1) begin n_fail++; $display("FAIL bp_taps_valid got %b exp 1", taps_valid); end
    endtask

    task automatic test_busy_ignore();
        int  cnt;
        int  viol;
        bit  seen;
        tap_dout_ready = 1'b1;
        load_start = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_start got %b exp 1", busy); end
        cfg_wr_addr  = 4'd3;
        cfg_wr_data  = 16'hBEEF;
        cfg_wr_valid = 1'b1;
        cnt = 0; viol = 0; seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (load_done === 1'b1) begin seen = 1; break; end
            if (cfg_wr_ready !== 1'b0) viol++;
            if (tap_dout_valid === 1'b1) cnt++;
            tick();
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL busy_timeout got %b exp 1", seen); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL busy_cfg_ready_low got %0d exp 0", viol); end
        n_checks++; if (cnt !== NT) begin n_fail++; $display("FAIL busy_nbeats got %0d exp %0d", cnt, NT); end
        n_checks++; if (cfg_wr_ready !== 1'b1) begin n_fail++; $display("FAIL busy_cfg_ready_done got %b exp 1", cfg_wr_ready); end
        n_checks++; if (taps_valid !== 1'b1) begin n_fail++; $display("FAIL busy_taps_valid_done got %b exp 1", taps_valid); end
        tick();
        load_start   = 1'b0;
        cfg_wr_valid = 1'b0;
        n_checks++; if (taps_valid !== 1'b0) begin n_fail++; $display("FAIL busy_taps_valid_wr got %b exp 0", taps_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_reload got %b exp 0", busy); end
        n_checks++; if (fir_enable !== 1'b1) begin n_fail++; $display("FAIL busy_fe_kept got %b exp 1", fir_enable); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_reload2 got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        for (int rep = 0; rep < 2; rep++) begin
            start_load();
            n_checks++; if (fir_enable !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_fe_low got %b exp 0", rep, fir_enable); end
            n_checks++; if (taps_valid !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_taps_valid_mid got %b exp 0", rep, taps_valid); end
            tick();
            n_checks++; if (fir_enable !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_fe_low2 got %b exp 0", rep, fir_enable); end
            tick();
            n_checks++; if (fir_enable !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_fe_high got %b exp 1", rep, fir_enable); end
            collect(1'b0, 100);
            n_checks++; if (nbeats !== NT) begin n_fail++; $display("FAIL b2b%0d_nbeats got %0d exp %0d", rep, nbeats, NT); end
            for (int i = 0; i < NT; i++) begin
                logic [TW-1:0] e;
                e = (i == 3) ? 16'hBEEF : 16'h0100 + 16'(i);
                n_checks++;
                if (beats[i] !== e) begin n_fail++; $display("FAIL b2b%0d_beat%0d got %h exp %h", rep, i, beats[i], e); end
            end
            n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL b2b%0d_ndone got %0d exp 1", rep, ndone); end
            n_checks++; if (taps_valid !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_taps_valid_end got %b exp 1", rep, taps_valid); end
        end
    endtask

    task automatic test_reset_mid_load();
        int  cnt;
        bit  hit;
        write_word(4'd3, 16'h0103);
        tap_dout_ready = 1'b1;
        start_load();
        cnt = 0; hit = 0;
        for (int c = 0; c < 100; c++) begin
            if (tap_dout_valid === 1'b1) begin
                if (cnt == 7) begin hit = 1; break; end
                cnt++;
            end
            tick();
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_mid_timeout got %b exp 1", hit); end
        n_checks++; if (tap_dout !== 16'h0107) begin n_fail++; $display("FAIL rst_mid_beat7 got %h exp 0107", tap_dout); end
        reset = 1'b0;
        tick();
        n_checks++; if (tap_dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b exp 0", tap_dout_valid); end
        n_checks++; if (fir_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fe got %b exp 0", fir_enable); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        n_checks++; if (tap_dout !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_dout got %h exp 0000", tap_dout); end
        reset = 1'b1;
        tick();
        start_load();
        collect(1'b0, 100);
        n_checks++; if (nbeats !== NT) begin n_fail++; $display("FAIL rst_reload_nbeats got %0d exp %0d", nbeats, NT); end
        for (int i = 0; i < NT; i++) begin
            n_checks++;
            if (beats[i] !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL rst_reload_beat%0d got %h exp %h", i, beats[i], 16'h0100 + 16'(i)); end
        end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL rst_reload_ndone got %0d exp 1", ndone); end
    endtask

    initial begin
        reset          = 1'b0;
        cfg_wr_addr    = '0;
        cfg_wr_data    = '0;
        cfg_wr_valid   = 1'b0;
        load_start     = 1'b0;
        tap_dout_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
